// File: rtl/dsp_pipe_ctrl.sv
// rtl/dsp_pipe_ctrl.sv - clock-enable/srst control for the DSP datapath pipeline
module dsp_pipe_ctrl #(
  parameter int STAGES    = 4,
  parameter int CNTW      = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              drain_req,
  input  logic              flush,
  output logic [STAGES-1:0] ce,
  output logic              srst,
  output logic [STAGES-1:0] stage_valid,
  output logic [CNTW-1:0]   occupancy,
  output logic              drain_done,
  output logic              busy
);

  localparam int L = STAGES - 1;

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

  state_t     state, state_nx;
  logic [3:0] fcnt, fcnt_nx;
  logic       full_run;
  logic       accept, out_fire;

  // A stage may advance when it or any stage downstream of it is empty.
  always_comb begin
    ce       = '0;
    full_run = 1'b1;
    for (int i = L; i >= 0; i--) begin
      full_run = full_run & stage_valid[i];
      ce[i]    = (~full_run | out_ready) & (state != FLUSH);
    end
  end

  assign in_ready  = ce[0] & (state == RUN) & ~flush;
  assign out_valid = stage_valid[L] & (state != FLUSH);
  assign accept    = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign busy      = (state != RUN) | (occupancy != '0);

  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    if (flush) begin
      state_nx = FLUSH;
      fcnt_nx  = 4'(FLUSH_CYC);
    end else begin
      case (state)
        RUN:   if (drain_req) state_nx = DRAIN;
        DRAIN: if (occupancy == '0) state_nx = RUN;
        FLUSH: begin
          fcnt_nx = fcnt - 4'd1;
          if (fcnt <= 4'd1) state_nx = RUN;
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      fcnt        <= 4'd0;
      srst        <= 1'b0;
      drain_done  <= 1'b0;
      stage_valid <= '0;
      occupancy   <= '0;
    end else begin
      state      <= state_nx;
      fcnt       <= fcnt_nx;
      srst       <= (state_nx == FLUSH);
      drain_done <= (state == DRAIN) && (occupancy == '0) && !flush;
      if (flush) begin
        stage_valid <= '0;
        occupancy   <= '0;
      end else begin
        if (ce[0]) stage_valid[0] <= accept;
        for (int i = 1; i < STAGES; i++) begin
          if (ce[i]) stage_valid[i] <= stage_valid[i-1];
        end
        if (accept && !out_fire) occupancy <= occupancy + CNTW'(1);
        else if (!accept && out_fire) occupancy <= occupancy - CNTW'(1);
      end
    end
  end

  occ_matches_valid: assert property (@(posedge clk) disable iff (reset)
    occupancy == CNTW'($countones(stage_valid)));

endmodule

// File: tb/tb_dsp_pipe_ctrl.sv
// tb/tb_dsp_pipe_ctrl.sv - scoreboard bench for dsp_pipe_ctrl
module tb_dsp_pipe_ctrl;
  localparam int ST = 4;
  localparam int CW = 4;

  logic          clk, reset, in_valid, in_ready, out_valid, out_ready;
  logic          drain_req, flush, srst, drain_done, busy;
  logic [ST-1:0] ce, stage_valid;
  logic [CW-1:0] occupancy;
  logic [7:0]    in_data;
  logic [7:0]    dp [ST];
  logic [7:0]    sb [$];
  int            total = 0;
  int            bad   = 0;
  int            fires = 0;

  logic [3:0] t1_sv [14] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                             4'b1111, 4'b1111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] dr_sv [4]  = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};

  dsp_pipe_ctrl #(.STAGES(ST), .CNTW(CW), .FLUSH_CYC(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .drain_req(drain_req),
    .flush(flush), .ce(ce), .srst(srst), .stage_valid(stage_valid),
    .occupancy(occupancy), .drain_done(drain_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in datapath: stage registers enabled by ce and cleared by srst.
  always @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < ST; i++) dp[i] <= 8'h00;
    end else begin
      if (ce[0]) dp[0] <= in_data;
      for (int i = 1; i < ST; i++) if (ce[i]) dp[i] <= dp[i-1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("occ_vs_sb", 32'(occupancy), 32'(sb.size()));
      if (out_valid && out_ready) begin
        fires++;
        if (sb.size() == 0) chk("sb_underflow", 32'(dp[ST-1]), 32'hffff_ffff);
        else chk("sb_data", 32'(dp[ST-1]), 32'(sb.pop_front()));
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      if (flush) sb.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drain_req = 1'b0; flush = 1'b0; in_data = 8'h00;
    #12;
    chk("rst_sv", 32'(stage_valid), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_srst", 32'(srst), 0);
    chk("rst_dd", 32'(drain_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_ce", 32'(ce), 32'hf);
    chk("rst_ir", 32'(in_ready), 1);
    reset = 1'b0;
    tick();

    // streaming 10 beats
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      in_valid = (k < 10);
      in_data  = 8'h10 + 8'(k);
      tick();
      chk("t1_sv", 32'(stage_valid), 32'(t1_sv[k]));
      chk("t1_ce", 32'(ce), 32'hf);
      chk("t1_ov", 32'(out_valid), 32'(t1_sv[k][3]));
    end
    chk("t1_fires", fires, 10);

    // backpressure
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin in_data = 8'h20 + 8'(k); tick(); end
    chk("t2_fill", 32'(stage_valid), 32'hf);
    out_ready = 1'b0; in_data = 8'h2f; #1;
    chk("t2_ir0", 32'(in_ready), 0);
    chk("t2_ce0", 32'(ce), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_hold_sv", 32'(stage_valid), 32'hf);
      chk("t2_hold_occ", 32'(occupancy), 4);
    end
    out_ready = 1'b1; in_valid = 1'b0; #1;
    chk("t2_ir1", 32'(in_ready), 1);
    chk("t2_ce1", 32'(ce), 32'hf);
    for (int k = 0; k < 4; k++) begin tick(); chk("t2_drain", 32'(stage_valid), 32'(dr_sv[k])); end

    // bubble collapse
    for (int k = 0; k < 4; k++) begin
      in_valid = (k % 2 == 0); in_data = 8'h30 + 8'(k); tick();
    end
    chk("t3_pat", 32'(stage_valid), 32'b1010);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h34; #1;
    chk("t3_ce_a", 32'(ce), 32'b0111);
    chk("t3_ir", 32'(in_ready), 1);
    tick();
    chk("t3_sv_a", 32'(stage_valid), 32'b1101);
    chk("t3_occ", 32'(occupancy), 3);
    chk("t3_ce_b", 32'(ce), 32'b0011);
    in_data = 8'h35; tick();
    chk("t3_sv_b", 32'(stage_valid), 32'hf);
    out_ready = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("t3_empty", 32'(stage_valid), 0);

    // graceful drain
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin in_data = 8'h40 + 8'(k); tick(); end
    in_valid = 1'b0; drain_req = 1'b1; tick();
    chk("t4_sv", 32'(stage_valid), 32'b1110);
    chk("t4_busy", 32'(busy), 1);
    drain_req = 1'b0; in_valid = 1'b1; in_data = 8'h4f; #1;
    chk("t4_ir0", 32'(in_ready), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_dd", 32'(drain_done), 32'(k == 3));
    end
    chk("t4_ir1", 32'(in_ready), 1);
    chk("t4_idle", 32'(busy), 0);
    in_valid = 1'b0; tick();
    chk("t4_dd_once", 32'(drain_done), 0);
    drain_req = 1'b1; tick();
    chk("t4e_dd0", 32'(drain_done), 0);
    chk("t4e_busy", 32'(busy), 1);
    chk("t4e_ir", 32'(in_ready), 0);
    drain_req = 1'b0; tick();
    chk("t4e_dd1", 32'(drain_done), 1);
    tick();
    chk("t4e_dd2", 32'(drain_done), 0);

    // hard flush
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin in_data = 8'h50 + 8'(k); tick(); end
    flush = 1'b1; in_data = 8'h5f; #1;
    chk("t5_ir", 32'(in_ready), 0);
    chk("t5_ov_pre", 32'(out_valid), 1);
    tick();
    chk("t5_sv", 32'(stage_valid), 0);
    chk("t5_occ", 32'(occupancy), 0);
    chk("t5_srst1", 32'(srst), 1);
    chk("t5_ov", 32'(out_valid), 0);
    chk("t5_ce", 32'(ce), 0);
    flush = 1'b0; tick();
    chk("t5_srst2", 32'(srst), 1);
    chk("t5_ir_fl", 32'(in_ready), 0);
    tick();
    chk("t5_srst3", 32'(srst), 0);
    chk("t5_ir_run", 32'(in_ready), 1);
    in_data = 8'ha5; tick();
    chk("t5_acc", 32'(stage_valid), 32'b0001);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("t5_emerge", 32'(out_valid), 1);
    tick();
    chk("t5_gone", 32'(stage_valid), 0);

    // async reset mid-stream
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin in_data = 8'h60 + 8'(k); tick(); end
    #2; reset = 1'b1; #1;
    chk("t6_sv", 32'(stage_valid), 0);
    chk("t6_occ", 32'(occupancy), 0);
    chk("t6_ov", 32'(out_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    sb.delete(); in_valid = 1'b0;
    #2; reset = 1'b0;
    tick();

    // async reset mid-flush
    flush = 1'b1; tick();
    chk("t7_srst", 32'(srst), 1);
    flush = 1'b0; #2; reset = 1'b1; #1;
    chk("t7_srst_rst", 32'(srst), 0);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_ir", 32'(in_ready), 1);
    #2; reset = 1'b0;
    tick();
    chk("t7_post", 32'(srst), 0);
    chk("t7_dd", 32'(drain_done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
